// File: rtl/pattern_generator_multi.sv
// Multi-mode test-pattern source for hdmi_tx; PATGEN_BORDER_EN adds a white frame border.
// Latency: 2 cycles from position inputs to pixelOut/pixelValid/frameStart.
// No backpressure: one pixel per pixelClock, mode state changes only at start of frame.
module pattern_generator_multi #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int H_WIDTH      = 10,
  parameter int V_WIDTH      = 10,
  parameter int BAR_COUNT    = 8,
  parameter int CHECKER_LOG2 = 5,
  parameter int SCROLL_STEP  = 4
) (
  input  logic               pixelClock,
  input  logic               resetN,
  input  logic [2:0]         modeSelect,
  input  logic [23:0]        solidColor,
  input  logic               inActiveDisplay,
  input  logic [H_WIDTH-1:0] hPosCounter,
  input  logic [V_WIDTH-1:0] vPosCounter,
  output logic [23:0]        pixelOut,
  output logic               pixelValid,
  output logic               frameStart,
  output logic [7:0]         frameCount
);

  localparam int XW = H_WIDTH + 1;
  localparam int BAR_W = H_ACTIVE / BAR_COUNT;
  localparam logic [XW-1:0] H_ACT_X = XW'(H_ACTIVE);
  localparam logic [23:0] WHITE = 24'hFFFFFF;

  if (BAR_COUNT < 1 || BAR_COUNT > 8 || SCROLL_STEP >= H_ACTIVE || H_WIDTH < 8 ||
      H_ACTIVE > 2**H_WIDTH || V_ACTIVE > 2**V_WIDTH ||
      CHECKER_LOG2 >= H_WIDTH || CHECKER_LOG2 >= V_WIDTH) begin : gBadParams
    $error("pattern_generator_multi: illegal parameter combination");
  end

  // Last threshold crossed wins, so x beyond BAR_COUNT*BAR_W clamps to the last bar.
  function automatic logic [2:0] barIndex(input logic [XW-1:0] x);
    logic [2:0] idx;
    idx = '0;
    for (int i = 1; i < BAR_COUNT; i++) begin
      if (x >= XW'(i * BAR_W)) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [23:0] barColor(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  logic [2:0]         activeMode;
  logic [23:0]        activeSolid;
  logic [H_WIDTH-1:0] scrollOffset;
  logic               frameLocked;

  logic               sof;
  logic [XW-1:0]      offsetSum;
  logic [H_WIDTH-1:0] offsetNext;
  logic [2:0]         effMode;
  logic [23:0]        effSolid;
  logic [H_WIDTH-1:0] effOffset;
  logic [XW-1:0]      scrollSum;
  logic [XW-1:0]      scrollX;
  logic [XW-1:0]      effX;

  assign sof        = inActiveDisplay && (hPosCounter == '0) && (vPosCounter == '0);
  assign offsetSum  = {1'b0, scrollOffset} + XW'(SCROLL_STEP);
  assign offsetNext = (offsetSum >= H_ACT_X) ? H_WIDTH'(offsetSum - H_ACT_X) : H_WIDTH'(offsetSum);

  // The start-of-frame pixel already uses the freshly sampled settings.
  assign effMode   = sof ? modeSelect : activeMode;
  assign effSolid  = sof ? solidColor : activeSolid;
  assign effOffset = sof ? offsetNext : scrollOffset;

  assign scrollSum = {1'b0, hPosCounter} + {1'b0, effOffset};
  assign scrollX   = (scrollSum >= H_ACT_X) ? scrollSum - H_ACT_X : scrollSum;
  assign effX      = (effMode == 3'd4) ? scrollX : {1'b0, hPosCounter};

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      activeMode   <= 3'd1;
      activeSolid  <= '0;
      scrollOffset <= '0;
      frameCount   <= '0;
      frameLocked  <= 1'b0;
    end else if (sof) begin
      activeMode   <= modeSelect;
      activeSolid  <= solidColor;
      scrollOffset <= offsetNext;
      frameCount   <= frameCount + 8'd1;
      frameLocked  <= 1'b1;
    end
  end

  logic [2:0]  s1Mode;
  logic [2:0]  s1Bar;
  logic        s1Checker;
  logic [7:0]  s1Grey;
  logic [23:0] s1Solid;
  logic        s1De;
  logic        s1Show;
  logic        s1Sof;
`ifdef PATGEN_BORDER_EN
  logic        s1Border;
`endif

  // s1Show blanks everything after a reset until the first frame start is seen.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      s1Mode    <= '0;
      s1Bar     <= '0;
      s1Checker <= 1'b0;
      s1Grey    <= '0;
      s1Solid   <= '0;
      s1De      <= 1'b0;
      s1Show    <= 1'b0;
      s1Sof     <= 1'b0;
`ifdef PATGEN_BORDER_EN
      s1Border  <= 1'b0;
`endif
    end else begin
      s1Mode    <= effMode;
      s1Bar     <= barIndex(effX);
      s1Checker <= hPosCounter[CHECKER_LOG2] ^ vPosCounter[CHECKER_LOG2];
      s1Grey    <= hPosCounter[7:0];
      s1Solid   <= effSolid;
      s1De      <= inActiveDisplay;
      s1Show    <= inActiveDisplay && (frameLocked || sof);
      s1Sof     <= sof;
`ifdef PATGEN_BORDER_EN
      s1Border  <= (hPosCounter == '0) || (hPosCounter == H_WIDTH'(H_ACTIVE - 1)) ||
                   (vPosCounter == '0) || (vPosCounter == V_WIDTH'(V_ACTIVE - 1));
`endif
    end
  end

  logic [23:0] patColor;

  always_comb begin
    patColor = '0;
    case (s1Mode)
      3'd0:       patColor = s1Solid;
      3'd1, 3'd4: patColor = barColor(s1Bar);
      3'd2:       patColor = {s1Grey, s1Grey, s1Grey};
      3'd3:       patColor = s1Checker ? WHITE : 24'h000000;
      default:    patColor = '0;
    endcase
`ifdef PATGEN_BORDER_EN
    if (s1Border) patColor = WHITE;
`endif
    if (!s1Show) patColor = '0;
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      pixelOut   <= '0;
      pixelValid <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      pixelOut   <= patColor;
      pixelValid <= s1De;
      frameStart <= s1Sof;
    end
  end

endmodule

// File: tb/tb_pattern_generator_multi.sv
// Bench for pattern_generator_multi: directed spec examples plus randomized pixels vs a frame-level model.
module tb_pattern_generator_multi;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int H_WIDTH      = 10;
  localparam int V_WIDTH      = 10;
  localparam int BAR_COUNT    = 8;
  localparam int CHECKER_LOG2 = 5;
  localparam int SCROLL_STEP  = 4;
  localparam int BAR_W        = H_ACTIVE / BAR_COUNT;

  logic               pixelClock = 1'b0;
  logic               resetN;
  logic [2:0]         modeSelect;
  logic [23:0]        solidColor;
  logic               inActiveDisplay;
  logic [H_WIDTH-1:0] hPosCounter;
  logic [V_WIDTH-1:0] vPosCounter;
  logic [23:0]        pixelOut;
  logic               pixelValid;
  logic               frameStart;
  logic [7:0]         frameCount;

  always #5 pixelClock = ~pixelClock;

  pattern_generator_multi #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_WIDTH(H_WIDTH), .V_WIDTH(V_WIDTH),
    .BAR_COUNT(BAR_COUNT), .CHECKER_LOG2(CHECKER_LOG2), .SCROLL_STEP(SCROLL_STEP)
  ) dut (
    .pixelClock(pixelClock), .resetN(resetN), .modeSelect(modeSelect), .solidColor(solidColor),
    .inActiveDisplay(inActiveDisplay), .hPosCounter(hPosCounter), .vPosCounter(vPosCounter),
    .pixelOut(pixelOut), .pixelValid(pixelValid), .frameStart(frameStart), .frameCount(frameCount)
  );

  int checks = 0;
  int failures = 0;

  logic [23:0] colTable [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Frame-level reference state.
  int          mMode;
  logic [23:0] mSolid;
  int          mFc;
  int          mOff;
  bit          mLocked;

  typedef struct { logic [23:0] pix; logic vld; logic fs; } exp_t;
  exp_t expQ[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] barOf(input int x);
    int idx;
    idx = x / BAR_W;
    if (idx > BAR_COUNT - 1) idx = BAR_COUNT - 1;
    return colTable[idx];
  endfunction

  function automatic logic [23:0] modelPixel(input int h, input int v);
    logic [7:0] g;
    int x;
    g = 8'(h);
`ifdef PATGEN_BORDER_EN
    if (h == 0 || h == H_ACTIVE - 1 || v == 0 || v == V_ACTIVE - 1) return 24'hFFFFFF;
`endif
    case (mMode)
      0: return mSolid;
      1: return barOf(h);
      2: return {g, g, g};
      3: return ((((h >> CHECKER_LOG2) ^ (v >> CHECKER_LOG2)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      4: begin
        x = h + mOff;
        if (x >= H_ACTIVE) x = x - H_ACTIVE;
        return barOf(x);
      end
      default: return 24'h000000;
    endcase
  endfunction

  task automatic modelReset();
    exp_t z;
    mMode = 1; mSolid = '0; mFc = 0; mOff = 0; mLocked = 0;
    z.pix = '0; z.vld = 1'b0; z.fs = 1'b0;
    expQ.delete();
    expQ.push_back(z);
    expQ.push_back(z);
  endtask

  // Called at a falling edge: check the pixel driven two cycles ago, then drive a new one.
  task automatic tick(input logic de, input int h, input int v);
    exp_t e;
    bit sof;
    if (expQ.size() == 2) begin
      e = expQ.pop_front();
      chk("pixelOut", 32'(pixelOut), 32'(e.pix));
      chk("pixelValid", 32'(pixelValid), 32'(e.vld));
      chk("frameStart", 32'(frameStart), 32'(e.fs));
      chk("frameCount", 32'(frameCount), 32'(mFc));
    end
    inActiveDisplay = de;
    hPosCounter = H_WIDTH'(h);
    vPosCounter = V_WIDTH'(v);
    sof = de && h == 0 && v == 0;
    if (sof) begin
      mMode = int'(modeSelect);
      mSolid = solidColor;
      mFc = (mFc + 1) % 256;
      mOff = (mOff + SCROLL_STEP) % H_ACTIVE;
      mLocked = 1;
    end
    e.pix = (de && mLocked) ? modelPixel(h, v) : 24'h000000;
    e.vld = de;
    e.fs = sof;
    expQ.push_back(e);
    @(posedge pixelClock);
    @(negedge pixelClock);
  endtask

  task automatic expectAt(input int h, input int v, input logic [23:0] lit, input string tag);
    tick(1'b1, h, v);
    tick(1'b0, 1, 1);
    chk(tag, 32'(pixelOut), 32'(lit));
    chk(tag, 32'(pixelValid), 32'(1'b1));
  endtask

  task automatic checkAllZero(input string tag);
    chk(tag, 32'(pixelOut), 32'h0);
    chk(tag, 32'(pixelValid), 32'h0);
    chk(tag, 32'(frameStart), 32'h0);
    chk(tag, 32'(frameCount), 32'h0);
  endtask

  initial begin
    logic [23:0] lit;
    int r;
    int h;
    int v;
    resetN = 1'b1;
    modeSelect = 3'd1;
    solidColor = '0;
    inActiveDisplay = 1'b0;
    hPosCounter = '0;
    vPosCounter = '0;
    #2 resetN = 1'b0;
    repeat (2) @(negedge pixelClock);
    checkAllZero("reset_state");
    resetN = 1'b1;
    modelReset();

    // Colour bars at the bar boundaries.
    modeSelect = 3'd1;
    tick(1'b1, 0, 0);
    expectAt(79, 1, 24'hFFFFFF, "bars_79");
    expectAt(80, 1, 24'hFFFF00, "bars_80");
    expectAt(559, 1, 24'h0000FF, "bars_559");
    expectAt(560, 1, 24'h000000, "bars_560");
`ifdef PATGEN_BORDER_EN
    lit = 24'hFFFFFF;
`else
    lit = 24'h000000;
`endif
    expectAt(639, 1, lit, "bars_639");

    // Mode change mid-frame waits for the next frame start.
    modeSelect = 3'd0;
    solidColor = 24'hABCDEF;
    tick(1'b1, 0, 0);
    expectAt(10, 50, 24'hABCDEF, "solid");
    modeSelect = 3'd2;
    solidColor = 24'h111111;
    expectAt(300, 100, 24'hABCDEF, "midframe_hold");
    tick(1'b1, 0, 0);
    tick(1'b0, 1, 1);
    chk("frameStart_pulse", 32'(frameStart), 32'h1);
    expectAt(300, 1, 24'h2C2C2C, "grey_300");
    chk("frameStart_low", 32'(frameStart), 32'h0);

    // Checkerboard.
    modeSelect = 3'd3;
    tick(1'b1, 0, 0);
    expectAt(31, 1, 24'h000000, "chk_31_1");
    expectAt(32, 1, 24'hFFFFFF, "chk_32_1");
    expectAt(32, 32, 24'h000000, "chk_32_32");

    // Asynchronous reset in the middle of a solid frame.
    modeSelect = 3'd0;
    solidColor = 24'h123456;
    tick(1'b1, 0, 0);
    tick(1'b1, 5, 5);
    tick(1'b1, 6, 5);
    resetN = 1'b0;
    #1;
    checkAllZero("midframe_reset");
    @(negedge pixelClock);
    resetN = 1'b1;
    modelReset();
    expectAt(100, 5, 24'h000000, "black_until_sof");
    chk("frameCount_after_reset", 32'(frameCount), 32'h0);

    // Scrolling bars: offset 12 after three frames, wraps to 0 after 160.
    modeSelect = 3'd4;
    for (int f = 0; f < 3; f++) begin
      tick(1'b1, 0, 0);
      tick(1'b1, 200, 1);
    end
    expectAt(68, 1, 24'hFFFF00, "scroll_68");
    for (int f = 0; f < 157; f++) begin
      tick(1'b1, 0, 0);
      tick(1'b1, $urandom_range(1, H_ACTIVE - 1), $urandom_range(1, V_ACTIVE - 1));
    end
    expectAt(79, 1, 24'hFFFFFF, "scroll_wrap_79");
    chk("frameCount_160", 32'(frameCount), 32'd160);

`ifdef PATGEN_BORDER_EN
    modeSelect = 3'd0;
    solidColor = 24'h123456;
    tick(1'b1, 0, 0);
    expectAt(0, 3, 24'hFFFFFF, "border_h0");
    expectAt(5, 5, 24'h123456, "border_inner");
    tick(1'b0, 5, 5);
    tick(1'b0, 1, 1);
    chk("border_de0", 32'(pixelOut), 32'h0);
`endif

    // Randomized pixels, modes, colours and occasional bad positions.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) modeSelect = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) solidColor = 24'($urandom);
      r = $urandom_range(0, 29);
      if (r == 0) begin
        tick(1'b1, 0, 0);
      end else begin
        h = (r < 4) ? $urandom_range(0, 1023) : $urandom_range(0, H_ACTIVE - 1);
        v = (r < 3) ? $urandom_range(0, 1023) : $urandom_range(0, V_ACTIVE - 1);
        tick($urandom_range(0, 3) != 0, h, v);
      end
    end
    tick(1'b0, 1, 1);
    tick(1'b0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
